// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: functional-unit writeback results and the
// common data bus payload they are funnelled onto.
package rv32i_types;

    localparam int NUM_FU_DEFAULT = 3;

    typedef struct packed {
        logic [7:0] rob_id;
    } rob_info_t;

    typedef struct packed {
        logic [5:0] rd;
    } rat_info_t;

    typedef struct packed {
        rob_info_t rob;
        rat_info_t rat;
    } reservation_entry_t;

    typedef struct packed {
        logic [4:0] rd_s;
    } inst_t;

    typedef struct packed {
        logic               valid;
        inst_t              inst;
        reservation_entry_t reservation_entry;
    } inst_info_t;

    typedef struct packed {
        logic        ready_for_writeback;
        logic [31:0] register_value;
        inst_info_t  inst_info;
    } fu_output_t;

    typedef struct packed {
        logic [31:0] rd_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [7:0]  rob_id;
        logic [5:0]  pd;
        logic [31:0] value;
        logic        rd_we;
        rvfi_t       rvfi;
    } cdb_t;

    // x0 destinations broadcast with rd_we low and a zeroed retire value.
    function automatic cdb_t make_cdb(input logic [7:0] rob_id, input logic [5:0] pd,
                                      input logic [31:0] value, input logic [4:0] rd_s);
        cdb_t c;
        c               = '0;
        c.rob_id        = rob_id;
        c.pd            = pd;
        c.value         = value;
        c.rd_we         = (rd_s != 5'd0);
        c.rvfi.rd_wdata = c.rd_we ? value : 32'd0;
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N. Pointer storage belongs to the instantiating block.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_idx,
    output logic          o_grant_valid
);

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (int'(i_ptr) + off) % N;
            if (!o_grant_valid && i_req[idx]) begin
                o_grant[idx]  = 1'b1;
                o_grant_idx   = PW'(idx);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selects one FU result per cycle into a
// single output register that the ROB / register file drains with cdb_ready.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU = NUM_FU_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  fu_output_t [NUM_FU-1:0] fu_out,
    output logic [NUM_FU-1:0]       fu_ack,
    input  logic                    flush,
    input  logic                    cdb_ready,
    output logic                    cdb_valid,
    output cdb_t                    cdb
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] w_elig;
    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_grant;
    logic [PW-1:0]     w_grant_idx;
    logic              w_grant_valid;
    logic              w_can_load;
    logic [PW-1:0]     w_next_ptr;
    cdb_t              w_next_cdb;

    logic [PW-1:0]     r_rr_ptr;
    logic              r_cdb_valid;
    cdb_t              r_cdb;

    assign w_can_load = !r_cdb_valid || cdb_ready;

    // Requests are masked rather than the grant, so backpressure and flush
    // also keep the pointer from advancing.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_elig[i] = fu_out[i].ready_for_writeback && fu_out[i].inst_info.valid;
        end
        w_req = (w_can_load && !flush) ? w_elig : '0;
    end

    rr_arbiter #(
        .N  (NUM_FU),
        .PW (PW)
    ) u_rr_arbiter (
        .i_req         (w_req),
        .i_ptr         (r_rr_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_comb begin
        w_next_cdb = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_grant[i]) begin
                w_next_cdb = make_cdb(fu_out[i].inst_info.reservation_entry.rob.rob_id,
                                      fu_out[i].inst_info.reservation_entry.rat.rd,
                                      fu_out[i].register_value,
                                      fu_out[i].inst_info.inst.rd_s);
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == PW'(NUM_FU - 1)) ? '0 : w_grant_idx + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb       <= '0;
        end else if (flush) begin
            r_cdb_valid <= 1'b0;
        end else if (w_grant_valid) begin
            r_cdb       <= w_next_cdb;
            r_cdb_valid <= 1'b1;
            r_rr_ptr    <= w_next_ptr;
        end else if (cdb_ready) begin
            r_cdb_valid <= 1'b0;
        end
    end

    // Acks are suppressed while reset is held even if FUs are requesting.
    assign fu_ack    = rst ? w_grant : '0;
    assign cdb_valid = r_cdb_valid;
    assign cdb       = r_cdb;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 3, meaning number of functional units (ALU, branch/compare, multiplier) sharing the common data bus.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 fu_out  input  NUM_FU x fu_output_t  per-FU result; a request is present when ready_for_writeback=1.
REQ-005 fu_ack  output  NUM_FU  per-FU accept; result captured in the cycle fu_ack[i]=1.
REQ-006 flush  input  1  mispredict squash; discards buffered and incoming results.
REQ-007 cdb_ready  input  1  consumer (ROB / physical register file) accepts the broadcast this cycle.
REQ-008 cdb_valid  output  1  broadcast present.
REQ-009 cdb  output  cdb_t  broadcast payload: rob_id[7:0], pd[5:0] from rat.rd, value[31:0], rd_we, rvfi.

Function
REQ-010 Request i is eligible when fu_out[i].ready_for_writeback=1 and fu_out[i].inst_info.valid=1.
REQ-011 Single output register; "can load" = !cdb_valid || cdb_ready.
REQ-012 When can load, flush=0 and any request is eligible, exactly one eligible request is granted; fu_ack one-hot on it, else all zero.
REQ-013 Grant is round-robin: search begins at rr_ptr, wraps modulo NUM_FU; first eligible index wins.
REQ-014 After a grant to index g, rr_ptr <= (g+1) mod NUM_FU; with no grant, rr_ptr holds.
REQ-015 Fairness: a continuously eligible requester is granted within NUM_FU grants.
REQ-016 fu_ack is combinational from current inputs and state; FUs hold ready_for_writeback and payload stable until acked.
REQ-017 Latency: granted result appears on cdb_valid/cdb the cycle after fu_ack; sustained throughput one result per cycle while cdb_ready=1.
REQ-018 cdb_valid && !cdb_ready holds cdb stable; no acks issued that cycle (backpressure).
REQ-019 Drain and refill in the same cycle (cdb_valid && cdb_ready && grant) loads new entry; cdb_valid stays 1.
REQ-020 Drain with no grant clears cdb_valid next cycle.
REQ-021 cdb.rob_id = inst_info.reservation_entry.rob.rob_id; cdb.pd = inst_info.reservation_entry.rat.rd; cdb.value = register_value.
REQ-022 cdb.rd_we = 1 only if inst.rd_s != 0; rvfi.rd_wdata = register_value if rd_we, else 0.
REQ-023 flush=1: fu_ack all zero, cdb_valid <= 0, rr_ptr unchanged; flush dominates cdb_ready and any request.
REQ-024 NUM_FU=1 degenerates to a registered pass-through with same handshake.

Reset
REQ-025 rst low asynchronously forces cdb_valid=0, cdb=0, rr_ptr=0; fu_ack=0 while in reset.
REQ-026 Reset mid-broadcast drops the held entry; first grant after release uses rr_ptr=0.

Structure
REQ-027 cdb_t and NUM_FU_DEFAULT belong in rv32i_types beside fu_output_t.
REQ-028 One sub-module, rr_arbiter (NUM_FU-wide request vector, pointer, one-hot grant, combinational), instantiated once; pointer register lives in cdb_arbiter.

Verification
REQ-029 Reset release, FU1 requests value 0x0000_00AA rob_id 5 rd 3, cdb_ready=1 -> fu_ack=3'b010 cycle 0; cycle 1 cdb_valid=1, value 0xAA, rob_id 5, rd_we=1.
REQ-030 All three FUs request continuously, cdb_ready=1 -> grants 0,1,2,0 on consecutive cycles; four broadcasts back-to-back.
REQ-031 cdb_valid=1, cdb_ready=0 for 3 cycles with FU2 requesting -> cdb unchanged, fu_ack=0 each cycle; cdb_ready=1 -> FU2 acked same cycle, broadcast next.
REQ-032 FU0 result with rd_s=0, value 0x1234 -> cdb_valid=1, rd_we=0, rvfi.rd_wdata=0.
REQ-033 flush asserted with cdb_valid=1 and FU0,FU1 requesting -> no ack, cdb_valid=0 next cycle, rr_ptr unchanged.
REQ-034 rst pulsed low mid-stream (rr_ptr=2) -> outputs clear immediately; after release, FU0 and FU2 requesting -> FU0 granted first.
